// File: rtl/fixed_qkv_broadcast.sv
// Registered one-to-N broadcast buffer: one input beat is held until every
// branch enabled for its frame has taken it, each on its own handshake.
module fixed_qkv_broadcast #(
    parameter int DATA_WIDTH      = 8,
    parameter int IN_PARALLELISM  = 3,
    parameter int IN_SIZE         = 3,
    parameter int NUM_BRANCH      = 3,
    parameter int BEATS_PER_FRAME = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_BRANCH-1:0] branch_mask,
    input  logic [DATA_WIDTH-1:0] data_in [IN_PARALLELISM*IN_SIZE],
    input  logic                  data_in_valid,
    output logic                  data_in_ready,
    output logic [DATA_WIDTH-1:0] data_out [IN_PARALLELISM*IN_SIZE],
    output logic [NUM_BRANCH-1:0] data_out_valid,
    input  logic [NUM_BRANCH-1:0] data_out_ready,
    output logic                  data_out_last
);

    localparam int NUM_ELEM = IN_PARALLELISM * IN_SIZE;
    localparam int CNT_W    = (BEATS_PER_FRAME > 1) ? $clog2(BEATS_PER_FRAME) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEATS_PER_FRAME - 1);

    logic [DATA_WIDTH-1:0] buf_data [NUM_ELEM];
    logic                  buf_valid;
    logic [NUM_BRANCH-1:0] pending;
    logic [CNT_W-1:0]      beat_cnt;
    logic [NUM_BRANCH-1:0] mask_q;
    logic                  last_q;

    logic [NUM_BRANCH-1:0] take;
    logic [NUM_BRANCH-1:0] remaining;
    logic [NUM_BRANCH-1:0] mask_eff;
    logic                  frame_first;
    logic                  frame_last;
    logic                  accept;

    assign data_out_valid = {NUM_BRANCH{buf_valid}} & pending;
    assign data_out       = buf_data;
    assign data_out_last  = buf_valid & last_q;

    assign take      = data_out_valid & data_out_ready;
    assign remaining = pending & ~take;

    // Ready looks through this cycle's branch handshakes so a drained buffer
    // refills in the same cycle without a bubble.
    assign data_in_ready = !buf_valid || (remaining == '0);
    assign accept        = data_in_valid && data_in_ready;

    assign frame_first = (beat_cnt == '0);
    assign frame_last  = (beat_cnt == CNT_LAST);
    assign mask_eff    = frame_first ? branch_mask : mask_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int e = 0; e < NUM_ELEM; e++) begin
                buf_data[e] <= '0;
            end
            buf_valid <= 1'b0;
            pending   <= '0;
            beat_cnt  <= '0;
            mask_q    <= '0;
            last_q    <= 1'b0;
        end else if (accept) begin
            buf_data  <= data_in;
            pending   <= mask_eff;
            last_q    <= frame_last;
            // A beat with no enabled branch is counted but never presented.
            buf_valid <= (mask_eff != '0);
            beat_cnt  <= frame_last ? '0 : beat_cnt + CNT_W'(1);
            if (frame_first) begin
                mask_q <= branch_mask;
            end
        end else begin
            pending <= remaining;
            if (remaining == '0) begin
                buf_valid <= 1'b0;
            end
        end
    end

endmodule

// File: doc/fixed_qkv_broadcast.md
# fixed_qkv_broadcast

Registered N-way broadcast stage that feeds one input activation stream to NUM_BRANCH consumers, e.g. the Q/K/V projections of each head in a multi-head self-attention block. Each branch has its own valid/ready pair and takes each beat exactly once, at its own time. Upstream is stalled only until every enabled branch has taken the current beat. A per-frame branch mask selects which branches receive a frame, supporting head gating and K/V-only or Q-only modes.

## Interface
- DATA_WIDTH, 8: element width, in bits.
- IN_PARALLELISM, 3: rows per beat.
- IN_SIZE, 3: columns per beat.
- NUM_BRANCH, 3: number of consumers; minimum 1.
- BEATS_PER_FRAME, 6: beats per input matrix (IN_NUM_PARALLELISM*IN_DEPTH); minimum 1.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- branch_mask  in  NUM_BRANCH  branch enables; sampled only on the first beat of a frame.
- data_in  in  DATA_WIDTH x (IN_PARALLELISM*IN_SIZE)  unpacked input beat.
- data_in_valid  in  1  input beat valid.
- data_in_ready  out  1  input beat accepted when high together with data_in_valid.
- data_out  out  DATA_WIDTH x (IN_PARALLELISM*IN_SIZE)  buffered beat; one copy shared by all branches.
- data_out_valid  out  NUM_BRANCH  per-branch valid.
- data_out_ready  in  NUM_BRANCH  per-branch ready.
- data_out_last  out  1  buffered beat is the last beat of its frame.

## Operation
- State registers:
  - buf_data: one beat.
  - buf_valid
  - pending[NUM_BRANCH]: branches that have not yet taken buf_data.
  - beat_cnt: 0..BEATS_PER_FRAME-1.
  - mask_q: frame mask.
  - last_q
- data_out_valid[i] = buf_valid & pending[i]. data_out = buf_data. data_out_last = buf_valid & last_q.
- A branch handshake happens when data_out_valid[i] & data_out_ready[i]. It clears pending[i].
- remaining = pending & ~(data_out_valid & data_out_ready).
- data_in_ready = !buf_valid | (remaining == 0). Upstream ready depends combinationally on downstream readies. This path is intended and gives full throughput.
- Effective mask:
  - When beat_cnt==0: mask_eff = branch_mask. On acceptance, branch_mask is also stored into mask_q.
  - Otherwise: mask_eff = mask_q.
- On input acceptance:
  - buf_data <= data_in.
  - pending <= mask_eff.
  - last_q <= (beat_cnt == BEATS_PER_FRAME-1).
  - buf_valid <= (mask_eff != 0).
  - beat_cnt increments and wraps to 0 after BEATS_PER_FRAME-1.
- If there is no acceptance and remaining == 0, then buf_valid <= 0.
- If mask_eff == 0, the beat is accepted and counted but never presented. The whole frame is dropped at one beat per cycle.
- No beat is ever presented twice to the same branch. No beat is skipped for an enabled branch.
- Changes to branch_mask in the middle of a frame are ignored until the next frame starts.
- With BEATS_PER_FRAME==1, every beat samples branch_mask and every beat has last set.

## Timing
- Reset values (asynchronous, while rst is low):
  - buf_valid=0, pending=0, beat_cnt=0, mask_q=0, last_q=0.
  - buf_data is cleared to all zeros.
  - Outputs: data_out_valid=0, data_out_last=0, data_out=0, data_in_ready=1.
- Latency: a beat accepted at edge N is visible on data_out_valid from cycle N+1.
- Throughput: 1 beat per cycle while all enabled branches hold ready high.
- Simultaneous refill: when the last pending branch takes a beat in the same cycle that a new beat is accepted, the new beat loads with no bubble cycle.
- Slow branch: holds data_in_ready low. The other branches see valid drop right after their own handshake and do not see it again until the next beat.
- Reset in the middle of a frame: the in-flight beat and the frame position are discarded. The next accepted beat is the first beat of a new frame.
- Handshake rules:
  - data_out and data_out_valid[i] are stable while a branch is pending and not yet taken.
  - Valid is never withdrawn before handshake, except by reset.

## Test plan
- Full-throughput broadcast: NUM_BRANCH=3, mask=3'b111, all ready high, 12 beats with values 1..12. Each branch receives 1..12 in order, one per cycle starting 1 cycle after the first accept. data_out_last is high on beats 6 and 12.
- Skewed readiness: branch 2 ready low for 4 cycles, others high, beats 7, 8. Branches 0 and 1 take 7 once. data_in_ready stays low until branch 2 takes 7. Beat 8 then loads in that same cycle.
- Frame masking: frame A with mask=3'b101, then frame B with mask=3'b010 applied at beat 3 of A. Branch 1 gets none of frame A's 6 beats. A's mask holds for the whole frame. B goes to branch 1 only.
- Zero mask: mask=0 for one frame of 6 beats. data_in_ready stays high and no data_out_valid is asserted. The next frame with mask=3'b111 is delivered and data_out_last is high on its 6th beat.
- Reset mid-frame: assert rst low after beat 3, with beat 3 pending on branch 0. All valids go to 0 immediately. After release, the first beat samples branch_mask and data_out_last asserts on the 6th beat.
- Random back-pressure: random valid and ready on each branch for 1000 beats. A scoreboard checks each enabled branch receives an exact copy in order with no duplicates.
